// File: rtl/float_rounder.sv
// FPU back end: denormalizes tiny results, rounds by RISC-V mode, handles overflow
// and packs an IEEE-754 single plus fflags. Two-stage pipeline with a global stall.
module float_rounder (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [23:0] man_in,
    input  logic [9:0]  exp_in,
    input  logic        sgn_in,
    input  logic        round_bit,
    input  logic        sticky_bit,
    input  logic        skip_round,
    input  logic        IV,
    input  logic        DZ,
    input  logic [2:0]  rm,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    // Reserved modes fall into the default (RNE) arm.
    function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                       input logic lsb, input logic rnd, input logic stk);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sgn & (rnd | stk);
            RM_RUP:  return ~sgn & (rnd | stk);
            RM_RMM:  return rnd;
            default: return rnd & (stk | lsb);
        endcase
    endfunction

    logic en;
    assign en        = !valid_out || ready_in;
    assign ready_out = en;

    // ---------------- Stage 1: denormalize ----------------
    logic        denorm;
    logic [10:0] shift_full;
    logic [4:0]  shift_amt;
    logic [49:0] shifted;
    logic        full_carry;
    logic [23:0] s1_man_d;
    logic [9:0]  s1_exp_d;
    logic        s1_rnd_d, s1_stk_d, s1_tiny_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        s1_man_d   = man_in;
        s1_exp_d   = exp_in;
        s1_rnd_d   = round_bit;
        s1_stk_d   = sticky_bit;
        denorm     = !skip_round && ($signed(exp_in) <= 10'sd0);
        shift_full = 11'd1 - {exp_in[9], exp_in};
        shift_amt  = (shift_full > 11'd26) ? 5'd26 : shift_full[4:0];
        shifted    = {man_in, round_bit, 25'd0} >> shift_amt;
        if (denorm) begin
            s1_man_d = shifted[49:26];
            s1_rnd_d = shifted[25];
            s1_stk_d = sticky_bit | (|shifted[24:0]);
            s1_exp_d = 10'd0;
        end
        // Tininess is judged after rounding at full precision: exp 0 that would carry is normal.
        full_carry = (&man_in) & round_inc(rm, sgn_in, man_in[0], round_bit, sticky_bit);
        s1_tiny_d  = !skip_round && (exp_in[9] || (exp_in == 10'd0 && !full_carry));
    end

    logic        s1_valid;
    logic [23:0] s1_man;
    logic [9:0]  s1_exp;
    logic        s1_sgn, s1_rnd, s1_stk, s1_tiny, s1_skip, s1_iv, s1_dz;
    logic [2:0]  s1_rm;

    // ---------------- Stage 2: round and pack ----------------
    logic        inc, inexact, ovf, ovf_inf;
    logic [24:0] man25;
    logic [23:0] man_rnd;
    logic [10:0] exp_rnd;
    logic [31:0] result_d;
    logic [4:0]  fflags_d;

    always_comb begin
        inc     = round_inc(s1_rm, s1_sgn, s1_man[0], s1_rnd, s1_stk);
        man25   = {1'b0, s1_man} + {24'd0, inc};
        man_rnd = man25[23:0];
        exp_rnd = {s1_exp[9], s1_exp};
        if (man25[24]) begin
            man_rnd = man25[24:1];
            exp_rnd = exp_rnd + 11'd1;
        end else if (s1_exp == 10'd0 && man25[23]) begin
            exp_rnd = 11'd1;
        end
        inexact = s1_rnd | s1_stk;
        ovf     = $signed(exp_rnd) >= 11'sd255;
        case (s1_rm)
            RM_RTZ:  ovf_inf = 1'b0;
            RM_RDN:  ovf_inf = s1_sgn;
            RM_RUP:  ovf_inf = ~s1_sgn;
            default: ovf_inf = 1'b1;
        endcase

        if (s1_skip) begin
            result_d = {s1_sgn, s1_exp[7:0], s1_man[22:0]};
            fflags_d = {s1_iv, s1_dz, 3'b000};
        end else if (ovf) begin
            result_d = ovf_inf ? {s1_sgn, 8'hFF, 23'd0} : {s1_sgn, 8'hFE, 23'h7FFFFF};
            fflags_d = {s1_iv, s1_dz, 1'b1, 1'b0, 1'b1};
        end else begin
            result_d = {s1_sgn, exp_rnd[7:0], man_rnd[22:0]};
            fflags_d = {s1_iv, s1_dz, 1'b0, s1_tiny & inexact, inexact};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_man    <= '0;
            s1_exp    <= '0;
            s1_sgn    <= 1'b0;
            s1_rnd    <= 1'b0;
            s1_stk    <= 1'b0;
            s1_tiny   <= 1'b0;
            s1_skip   <= 1'b0;
            s1_iv     <= 1'b0;
            s1_dz     <= 1'b0;
            s1_rm     <= '0;
            valid_out <= 1'b0;
            result    <= '0;
            fflags    <= '0;
        end else if (en) begin
            s1_valid  <= valid_in;
            s1_man    <= s1_man_d;
            s1_exp    <= s1_exp_d;
            s1_sgn    <= sgn_in;
            s1_rnd    <= s1_rnd_d;
            s1_stk    <= s1_stk_d;
            s1_tiny   <= s1_tiny_d;
            s1_skip   <= skip_round;
            s1_iv     <= IV;
            s1_dz     <= DZ;
            s1_rm     <= rm;
            valid_out <= s1_valid;
            result    <= result_d;
            fflags    <= fflags_d;
        end
    end

endmodule
